// File: rtl/eightto3_pending_encoder_pkg.sv
// ============================================================================
// Module   : eightto3_pending_encoder_pkg
// Brief    : Shared widths, state encoding and code-to-one-hot mapping.
// Revision : 1.0
// ============================================================================
`default_nettype none

package eightto3_pending_encoder_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Same mapping as the 3-to-8 decoder: code k lights bit k.
  function automatic logic [N_REQ-1:0] onehot3(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] w_oh;
    w_oh       = '0;
    w_oh[code] = 1'b1;
    return w_oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/eightto3_pending_encoder_if.sv
// ============================================================================
// Module   : eightto3_pending_encoder_if
// Brief    : Request/code handshake bundle between a requester and the encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface eightto3_pending_encoder_if;

  logic                                        en;
  logic [eightto3_pending_encoder_pkg::N_REQ-1:0]  req;
  logic                                        ack;
  logic [eightto3_pending_encoder_pkg::CODE_W-1:0] code;
  logic                                        valid;
  logic [3:0]                                  pend_cnt;
  logic                                        coalesce;

  modport master (
    output en, req, ack,
    input  code, valid, pend_cnt, coalesce
  );

  modport slave (
    input  en, req, ack,
    output code, valid, pend_cnt, coalesce
  );

endinterface

`default_nettype wire

// File: rtl/eightto3_pending_encoder_prio_pick8.sv
// ============================================================================
// Module   : prio_pick8
// Brief    : Combinational 8-bit priority select returning the winning index.
// Revision : 1.0
// ============================================================================
`default_nettype none

module prio_pick8 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [7:0] x,
  output logic [2:0] idx
);

  generate
    if (HIGH_FIRST) begin : g_high_first
      // Ascending scan: the last hit is the highest set bit.
      always_comb begin
        idx = '0;
        for (int i = 0; i < 8; i++) begin
          if (x[i]) idx = 3'(i);
        end
      end
    end else begin : g_low_first
      always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
          if (x[i]) idx = 3'(i);
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/eightto3_pending_encoder.sv
// ============================================================================
// Module   : eightto3_pending_encoder
// Brief    : Registered 8-to-3 priority encoder with pending capture and
//            valid/ack delivery of one code at a time.
// Revision : 1.0
// ============================================================================
`default_nettype none

module eightto3_pending_encoder
  import eightto3_pending_encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  eightto3_pending_encoder_if.slave bus
);

  state_t              r_state;
  state_t              w_state_next;
  logic [N_REQ-1:0]    r_pending;
  logic [CODE_W-1:0]   r_code;
  logic [CODE_W-1:0]   w_code_next;
  logic [3:0]          r_pend_cnt;
  logic [3:0]          w_cnt_next;
  logic                r_coalesce;
  logic                w_coalesce_next;
  logic [N_REQ-1:0]    w_clr;
  logic [N_REQ-1:0]    w_set;
  logic [N_REQ-1:0]    w_pend_next;
  logic [CODE_W-1:0]   w_pick;

  prio_pick8 #(
    .HIGH_FIRST (HIGH_FIRST)
  ) u_pick (
    .x   (w_pend_next),
    .idx (w_pick)
  );

  // Capture terms: a same-cycle set beats the clear so a re-request re-arms.
  always_comb begin
    w_clr           = (r_state == PRESENT && bus.ack) ? onehot3(r_code) : '0;
    w_set           = bus.req & {N_REQ{bus.en}};
    w_pend_next     = (r_pending & ~w_clr) | w_set;
    w_coalesce_next = |(w_set & r_pending & ~w_clr);
    w_cnt_next      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cnt_next = w_cnt_next + {3'b000, w_pend_next[i]};
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_code_next  = r_code;
    case (r_state)
      IDLE: begin
        if (|w_pend_next) begin
          w_state_next = PRESENT;
          w_code_next  = w_pick;
        end
      end
      PRESENT: begin
        if (bus.ack) begin
          if (|w_pend_next) begin
            w_code_next = w_pick;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_code     <= '0;
      r_pend_cnt <= '0;
      r_coalesce <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pending  <= w_pend_next;
      r_code     <= w_code_next;
      r_pend_cnt <= w_cnt_next;
      r_coalesce <= w_coalesce_next;
    end
  end

  assign bus.code     = r_code;
  assign bus.valid    = (r_state == PRESENT);
  assign bus.pend_cnt = r_pend_cnt;
  assign bus.coalesce = r_coalesce;

endmodule

`default_nettype wire

// File: doc/eightto3_pending_encoder.md
Name: eightto3_pending_encoder

Overview:
- Registered 8-to-3 priority encoder with a request-capture register and a valid/ack handshake.
- Sits on the request side of the 3-bit code bus and is the inverse of the team's 3-to-8 one-hot decoder: request line k produces code k, and decoding code k gives y[k].
- Request pulses are captured into pending bits. The block then presents the index of one pending line at a time until that index is acknowledged.

Parameters:
- HIGH_FIRST, default 1: priority direction. 1 means req[7] has highest priority; 0 means req[0] has highest priority.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- en  input  1  capture enable. When 0, new req bits are ignored; already-pending bits still drain.
- req  input  8  request lines, sampled every clk edge. A bit that is 1 on an edge sets its pending bit.
- ack  input  1  consumer accepts code. Meaningful only while valid=1.
- code  output  3  registered index of the presented request
- valid  output  1  registered. When 1, code holds a pending request.
- pend_cnt  output  4  registered count of pending bits, 0..8
- coalesce  output  1  registered 1-cycle pulse. Set when an enabled req bit arrives while that bit is already pending and is not being cleared this cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pending=8'h00, state=IDLE.
  - code=3'b000, valid=0, pend_cnt=0, coalesce=0.
- Next-state terms, evaluated each edge:
  - clr = one-hot(code) when valid&&ack, else 0.
  - set = req & {8{en}}.
  - pending_next = (pending & ~clr) | set. Set wins over clear on the same bit, so a re-request during ack re-arms that bit.
- pend_cnt is registered as popcount(pending_next).
- coalesce is registered as |(set & pending & ~clr).
- Priority select pick(x), combinational:
  - HIGH_FIRST=1: index of the highest set bit of x.
  - HIGH_FIRST=0: index of the lowest set bit of x.
  - pick is undefined for x=0 and is never used in that case.
- State machine:
  - IDLE (valid=0): if pending_next != 0, load code=pick(pending_next), set valid=1, go to PRESENT. Otherwise stay in IDLE with code unchanged.
  - PRESENT (valid=1), ack=0: code and valid hold stable, even if a higher-priority request arrives. That request is captured in pending only.
  - PRESENT, ack=1, pending_next != 0: code=pick(pending_next) and valid stays 1. This gives back-to-back delivery with no bubble.
  - PRESENT, ack=1, pending_next == 0: valid=0, go to IDLE, code holds its last value.
- Latency: req asserted before edge n gives valid=1 and the matching code after edge n, provided the block was IDLE. This is 1 cycle.
- Throughput: one code per cycle while ack is held high.
- ack while valid=0 is ignored: it clears nothing and causes no error.
- en=0 with pending != 0: draining continues normally.
- Reset mid-handshake drops all pending requests. No code is delivered after reset is released until a new req arrives.
- Invariant: valid=1 implies pending[code]=1.

Decomposition:
- Shared package holds:
  - N_REQ=8 and CODE_W=3.
  - A state enum {IDLE, PRESENT}.
  - A pure function onehot3(code) returning the 8-bit one-hot, identical to the decoder mapping. The encoder uses it for clr and the bench uses it for checking.
- One sub-module: prio_pick8. It is combinational: 8-bit in, 3-bit index out, with a HIGH_FIRST parameter. It is instantiated once and unit-testable on its own.
- Popcount and capture logic live inline in the top module.

Test Plan:
- Reset then idle:
  - rst=1 asynchronously mid-cycle → outputs clear immediately: code=0, valid=0, pend_cnt=0.
  - Release rst with req=0 for 5 cycles → valid stays 0.
- Single request:
  - req=8'h20 for 1 cycle, ack=0 → next cycle code=5, valid=1, pend_cnt=1; held 3 cycles.
  - Then ack=1 for 1 cycle → valid=0, pend_cnt=0.
- Priority and back-to-back:
  - HIGH_FIRST=1, req=8'h91 for 1 cycle → code=7, pend_cnt=3.
  - Then ack held high → code sequence 7, 4, 0 on consecutive cycles, then valid=0.
  - Repeat with HIGH_FIRST=0 → sequence 0, 4, 7.
- Hold stability:
  - Presenting code=2 with ack=0; pulse req=8'h80 → code stays 2, pend_cnt goes 1→2.
  - ack → next code=7.
- Simultaneous ack and re-request:
  - Presenting code=3; assert ack=1 with req=8'h08 in the same cycle → valid stays 1, code=3, pend_cnt=1, coalesce=0.
  - Separately, req=8'h08 while code=3 and ack=0 → coalesce pulses for 1 cycle.
- Enable gating:
  - en=0, req=8'hFF → valid stays 0.
  - With pending 8'h06 and en=0 → drains 2 then 1 under ack, with no new captures.
